// File: rtl/mem_wb_stage.sv
// Memory-access / writeback stage: byte-lane stores, load extension, wait-state stall,
// hung-access timeout and the registered W-stage result with forwarding outputs.
module mem_wb_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] MemWriteDataM,
    input  logic [31:0] LUI_or_AUIPCM,
    input  logic [31:0] PCPlus4M,
    input  logic [4:0]  rdM,
    input  logic [2:0]  funct3M,
    input  logic        MemWriteM,
    input  logic [2:0]  ResultSrcM,
    input  logic        RegWriteM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] ALUOutM2E,
    output logic [31:0] ResultW,
    output logic [4:0]  rdW,
    output logic        RegWriteW,
    output logic        stallM,
    output logic        bus_err,
    output logic        misalign_err
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_wait_cnt, w_cnt_nxt;
    logic [31:0]   r_result;
    logic [4:0]    r_rd;
    logic          r_regwrite, r_bus_err, r_misalign_err;

    logic          w_access, w_half, w_word, w_misalign, w_req, w_timeout, w_stall;
    logic [31:0]   w_wdata, w_load, w_result;
    logic [3:0]    w_strb;
    logic [7:0]    w_byte;
    logic [15:0]   w_hword;

    assign w_access   = MemWriteM | (ResultSrcM == 3'b001);
    assign w_half     = (funct3M[1:0] == 2'b01);
    assign w_word     = (funct3M[1:0] == 2'b10);
    assign w_misalign = w_access & ((w_half & ALUOutM[0]) | (w_word & (|ALUOutM[1:0])));
    assign w_req      = w_access & ~w_misalign;
    // The TIMEOUT-th request cycle aborts unless ready arrives in that same cycle.
    assign w_timeout  = w_req & ~dmem_ready & (r_wait_cnt == LAST);
    assign w_stall    = w_req & ~dmem_ready & ~w_timeout;

    always_comb begin
        w_wdata = MemWriteDataM;
        w_strb  = 4'b1111;
        case (funct3M[1:0])
            2'b00: begin
                w_wdata = {4{MemWriteDataM[7:0]}};
                w_strb  = 4'b0001 << ALUOutM[1:0];
            end
            2'b01: begin
                w_wdata = {2{MemWriteDataM[15:0]}};
                w_strb  = 4'b0011 << {ALUOutM[1], 1'b0};
            end
            default: ;
        endcase
    end

    assign dmem_req   = w_req;
    assign dmem_we    = w_req & MemWriteM;
    assign dmem_addr  = {ALUOutM[31:2], 2'b00};
    assign dmem_wdata = w_wdata;
    assign dmem_wstrb = dmem_we ? w_strb : 4'b0000;

    always_comb begin
        w_byte = dmem_rdata[7:0];
        case (ALUOutM[1:0])
            2'b01:   w_byte = dmem_rdata[15:8];
            2'b10:   w_byte = dmem_rdata[23:16];
            2'b11:   w_byte = dmem_rdata[31:24];
            default: w_byte = dmem_rdata[7:0];
        endcase
        w_hword = ALUOutM[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (funct3M)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_hword[15]}}, w_hword};
            3'b100:  w_load = {24'h0, w_byte};
            3'b101:  w_load = {16'h0, w_hword};
            default: w_load = dmem_rdata;
        endcase
    end

    always_comb begin
        case (ResultSrcM)
            3'b001:  w_result = w_load;
            3'b010:  w_result = PCPlus4M;
            3'b011:  w_result = LUI_or_AUIPCM;
            default: w_result = ALUOutM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_wait_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_req & ~dmem_ready) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = CW'(1);
                end
            end
            S_WAIT: begin
                // A vanished request is treated like completion so the FSM never sticks.
                if (~w_req | dmem_ready | w_timeout) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_wait_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_result       <= '0;
            r_rd           <= '0;
            r_regwrite     <= 1'b0;
            r_bus_err      <= 1'b0;
            r_misalign_err <= 1'b0;
        end else begin
            r_bus_err      <= 1'b0;
            r_misalign_err <= 1'b0;
            if (~w_stall) begin
                r_rd <= rdM;
                if (w_timeout | w_misalign) begin
                    r_result       <= '0;
                    r_regwrite     <= 1'b0;
                    r_bus_err      <= w_timeout;
                    r_misalign_err <= w_misalign;
                end else begin
                    r_result   <= w_result;
                    r_regwrite <= RegWriteM;
                end
            end
        end
    end

    assign ALUOutM2E    = ALUOutM;
    assign ResultW      = r_result;
    assign rdW          = r_rd;
    assign RegWriteW    = r_regwrite;
    assign stallM       = w_stall;
    assign bus_err      = r_bus_err;
    assign misalign_err = r_misalign_err;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: each instruction pushes its expected W-stage result;
// a monitor pops and compares after every non-stalled update.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ALUOutM, MemWriteDataM, LUI_or_AUIPCM, PCPlus4M, dmem_rdata;
    logic [4:0]  rdM;
    logic [2:0]  funct3M, ResultSrcM;
    logic        MemWriteM, RegWriteM, dmem_ready;
    logic        dmem_req, dmem_we, RegWriteW, stallM, bus_err, misalign_err;
    logic [31:0] dmem_addr, dmem_wdata, ALUOutM2E, ResultW;
    logic [3:0]  dmem_wstrb;
    logic [4:0]  rdW;

    mem_wb_stage #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .ALUOutM(ALUOutM), .MemWriteDataM(MemWriteDataM),
        .LUI_or_AUIPCM(LUI_or_AUIPCM), .PCPlus4M(PCPlus4M), .rdM(rdM), .funct3M(funct3M),
        .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .RegWriteM(RegWriteM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready),
        .dmem_rdata(dmem_rdata), .ALUOutM2E(ALUOutM2E), .ResultW(ResultW), .rdW(rdW),
        .RegWriteW(RegWriteW), .stallM(stallM), .bus_err(bus_err), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [31:0] res;
        logic [4:0]  rd;
        logic        rw;
        logic        be;
        logic        me;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Monitor: a W update happens on every edge where the stage was not stalled.
    logic upd;
    exp_t e;
    initial begin
        forever begin
            @(posedge clk);
            upd = !stallM && !reset;
            @(negedge clk);
            if (upd) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_update: got ResultW %h rdW %0d, expected none", ResultW, rdW);
                end else begin
                    e = q.pop_front();
                    chk({e.nm, " ResultW"},      ResultW,             e.res);
                    chk({e.nm, " rdW"},          32'(rdW),            32'(e.rd));
                    chk({e.nm, " RegWriteW"},    32'(RegWriteW),      32'(e.rw));
                    chk({e.nm, " bus_err"},      32'(bus_err),        32'(e.be));
                    chk({e.nm, " misalign_err"}, 32'(misalign_err),   32'(e.me));
                end
            end
        end
    end

    // Drives one M-stage instruction until it leaves the stage. rdy_dly: stall cycles
    // before dmem_ready rises (0 = same cycle, -1 = never).
    task automatic run(input string nm, input logic [31:0] alu, input logic [31:0] wd,
                       input logic [4:0] rd, input logic [2:0] f3, input logic [2:0] rs,
                       input logic mw, input logic rw, input logic [31:0] rdata,
                       input int rdy_dly, input int exp_stall,
                       input logic exp_req, input logic exp_we, input logic [31:0] exp_wd,
                       input logic [3:0] exp_strb, input logic [31:0] exp_res,
                       input logic exp_rw, input logic exp_be, input logic exp_me);
        int stalls;
        ALUOutM       = alu;
        MemWriteDataM = wd;
        rdM           = rd;
        funct3M       = f3;
        ResultSrcM    = rs;
        MemWriteM     = mw;
        RegWriteM     = rw;
        dmem_rdata    = rdata;
        dmem_ready    = (rdy_dly == 0);
        q.push_back('{nm, exp_res, rd, exp_rw, exp_be, exp_me});
        @(negedge clk);
        chk({nm, " dmem_req"},   32'(dmem_req),   32'(exp_req));
        chk({nm, " dmem_we"},    32'(dmem_we),    32'(exp_we));
        chk({nm, " dmem_wstrb"}, 32'(dmem_wstrb), 32'(exp_strb));
        chk({nm, " ALUOutM2E"},  ALUOutM2E,       alu);
        if (exp_req) chk({nm, " dmem_addr"}, dmem_addr, {alu[31:2], 2'b00});
        if (exp_we)  chk({nm, " dmem_wdata"}, dmem_wdata, exp_wd);
        stalls = 0;
        while (stallM === 1'b1 && stalls <= 40) begin
            stalls++;
            @(posedge clk);
            #1;
            if (stalls == rdy_dly) dmem_ready = 1'b1;
            @(negedge clk);
        end
        chk({nm, " stall_cycles"}, 32'(stalls), 32'(exp_stall));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        ALUOutM = 32'h0; MemWriteDataM = 32'h0; rdM = 5'd0; funct3M = 3'b010;
        ResultSrcM = 3'b000; MemWriteM = 1'b0; RegWriteM = 1'b0;
        dmem_ready = 1'b0; dmem_rdata = 32'h0;
        LUI_or_AUIPCM = 32'hABCDE000;
        PCPlus4M      = 32'h00001004;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset ResultW",      ResultW,            32'h0);
        chk("reset rdW",          32'(rdW),           32'h0);
        chk("reset RegWriteW",    32'(RegWriteW),     32'h0);
        chk("reset bus_err",      32'(bus_err),       32'h0);
        chk("reset misalign_err", 32'(misalign_err),  32'h0);
        chk("reset stallM",       32'(stallM),        32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        //  name     alu           wdata         rd  f3      rs      mw rw rdata        dly st req we exp_wd       strb     res          rw be me
        run("lw",    32'h100, 32'h0,        5,  3'b010, 3'b001, 0, 1, 32'hDEADBEEF, 0, 0, 1, 0, 32'h0,        4'b0000, 32'hDEADBEEF, 1, 0, 0);
        run("lb",    32'h103, 32'h0,        6,  3'b000, 3'b001, 0, 1, 32'h80000000, 3, 3, 1, 0, 32'h0,        4'b0000, 32'hFFFFFF80, 1, 0, 0);
        run("lbu",   32'h103, 32'h0,        7,  3'b100, 3'b001, 0, 1, 32'h80000000, 3, 3, 1, 0, 32'h0,        4'b0000, 32'h00000080, 1, 0, 0);
        run("lh_hi", 32'h102, 32'h0,        8,  3'b001, 3'b001, 0, 1, 32'h80011234, 0, 0, 1, 0, 32'h0,        4'b0000, 32'hFFFF8001, 1, 0, 0);
        run("lhu",   32'h102, 32'h0,        8,  3'b101, 3'b001, 0, 1, 32'h80011234, 0, 0, 1, 0, 32'h0,        4'b0000, 32'h00008001, 1, 0, 0);
        run("lh_lo", 32'h100, 32'h0,        9,  3'b001, 3'b001, 0, 1, 32'h80011234, 1, 1, 1, 0, 32'h0,        4'b0000, 32'h00001234, 1, 0, 0);
        run("sh",    32'h202, 32'h0000ABCD, 0,  3'b001, 3'b000, 1, 0, 32'h0,        0, 0, 1, 1, 32'hABCDABCD, 4'b1100, 32'h00000202, 0, 0, 0);
        run("sb",    32'h201, 32'h000000A5, 0,  3'b000, 3'b000, 1, 0, 32'h0,        1, 1, 1, 1, 32'hA5A5A5A5, 4'b0010, 32'h00000201, 0, 0, 0);
        run("sw",    32'h204, 32'h12345678, 0,  3'b010, 3'b000, 1, 0, 32'h0,        0, 0, 1, 1, 32'h12345678, 4'b1111, 32'h00000204, 0, 0, 0);
        run("lw_n14",32'h110, 32'h0,        3,  3'b010, 3'b001, 0, 1, 32'h0BADF00D, 14,14, 1, 0, 32'h0,       4'b0000, 32'h0BADF00D, 1, 0, 0);
        run("lw_n15",32'h114, 32'h0,        4,  3'b010, 3'b001, 0, 1, 32'hCAFE0001, 15,15, 1, 0, 32'h0,       4'b0000, 32'hCAFE0001, 1, 0, 0);
        run("lw_hung",32'h300,32'h0,        9,  3'b010, 3'b001, 0, 1, 32'h11111111, -1,15, 1, 0, 32'h0,       4'b0000, 32'h0,        0, 1, 0);
        run("alu",   32'h55,  32'h0,        10, 3'b010, 3'b000, 0, 1, 32'h0,        0, 0, 0, 0, 32'h0,        4'b0000, 32'h00000055, 1, 0, 0);
        run("sw_mis",32'h102, 32'h99999999, 0,  3'b010, 3'b000, 1, 0, 32'h0,        0, 0, 0, 0, 32'h0,        4'b0000, 32'h0,        0, 0, 1);
        run("alu2",  32'h1234,32'h0,        11, 3'b010, 3'b000, 0, 1, 32'h0,        0, 0, 0, 0, 32'h0,        4'b0000, 32'h00001234, 1, 0, 0);
        run("lh_mis",32'h101, 32'h0,        12, 3'b001, 3'b001, 0, 1, 32'h0,        0, 0, 0, 0, 32'h0,        4'b0000, 32'h0,        0, 0, 1);
        run("pc4",   32'h77,  32'h0,        1,  3'b010, 3'b010, 0, 1, 32'h0,        0, 0, 0, 0, 32'h0,        4'b0000, 32'h00001004, 1, 0, 0);
        run("lui",   32'h77,  32'h0,        2,  3'b010, 3'b011, 0, 1, 32'h0,        0, 0, 0, 0, 32'h0,        4'b0000, 32'hABCDE000, 1, 0, 0);
        run("rs111", 32'h77,  32'h0,        14, 3'b010, 3'b111, 0, 1, 32'h0,        0, 0, 0, 0, 32'h0,        4'b0000, 32'h00000077, 1, 0, 0);

        // Reset during the second WAIT cycle of a hung load; the load is then held again.
        ALUOutM = 32'h300; rdM = 5'd13; funct3M = 3'b010; ResultSrcM = 3'b001;
        MemWriteM = 1'b0; RegWriteM = 1'b1; dmem_ready = 1'b0;
        @(negedge clk);
        chk("rstwait stall1", 32'(stallM), 32'h1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rstwait stall2", 32'(stallM), 32'h1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rstwait dmem_req", 32'(dmem_req), 32'h1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        fork
            run("post_rst_hung", 32'h300, 32'h0, 13, 3'b010, 3'b001, 0, 1, 32'h0, -1, 15,
                1, 0, 32'h0, 4'b0000, 32'h0, 0, 1, 0);
            begin
                @(negedge clk);
                chk("rstwait ResultW",      ResultW,           32'h0);
                chk("rstwait rdW",          32'(rdW),          32'h0);
                chk("rstwait RegWriteW",    32'(RegWriteW),    32'h0);
                chk("rstwait bus_err",      32'(bus_err),      32'h0);
                chk("rstwait misalign_err", 32'(misalign_err), 32'h0);
            end
        join
        run("alu_end", 32'hF0F0, 32'h0, 15, 3'b010, 3'b000, 0, 1, 32'h0, 0, 0,
            0, 0, 32'h0, 4'b0000, 32'h0000F0F0, 1, 0, 0);

        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard drained", 32'(q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
